// File: rtl/alu_result_stage_if.sv
// Handshake and data bus between the ALU generate stage, the result stage,
// and the writeback consumer.
interface alu_result_stage_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cout;
  logic [2:0]       opsel;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, s, cout, opsel, mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, s, cout, opsel, mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives Z/N/C/V at capture, buffers results in a
// small circular FIFO toward writeback, and keeps a sticky overflow flag.
module alu_result_stage #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_stage_if.slave        bus,
  input  logic                     clr_sticky,
  output logic                     sticky_v,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [3:0]       flag_q  [DEPTH];
  logic [3:0]       flag_d  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sticky_q, sticky_d;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             push;
  logic             pop;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic             unused_opsel;

  // opsel only qualifies the flags through mode; it carries no state here.
  assign unused_opsel = ^bus.opsel;

  assign in_ready_int  = (count_q < CW'(DEPTH));
  assign out_valid_int = (count_q != '0);
  assign push          = bus.in_valid & in_ready_int;
  assign pop           = out_valid_int & bus.out_ready;

  always_comb begin
    flag_z = (bus.s == '0);
    flag_n = bus.s[WIDTH-1];
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (!bus.mode) begin
      flag_c = bus.cout[WIDTH-1];
      flag_v = bus.cout[WIDTH-1] ^ bus.cout[WIDTH-2];
    end
  end

  always_comb begin
    data_d   = data_q;
    flag_d   = flag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (push) begin
      data_d[wr_ptr_q] = bus.s;
      flag_d[wr_ptr_q] = {flag_z, flag_n, flag_c, flag_v};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a same-cycle overflow is never lost.
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (push && flag_v) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        flag_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      flag_q   <= flag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.result    = data_q[rd_ptr_q];
  assign bus.flags     = flag_q[rd_ptr_q];
  assign sticky_v      = sticky_q;
  assign count         = count_q;

endmodule
